// File: rtl/onehot_encoder_stream_pkg.sv
// onehot_enc_pkg: FSM state encoding and a constant clog2 shared by the one-hot stream encoder.
package onehot_enc_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EMIT = 2'd1;
   localparam logic [1:0] ERR  = 2'd2;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/onehot_encoder_stream_lowest_set_idx.sv
// lowest_set_idx: combinational priority encoder returning the lowest set bit, plus any/single flags.
module lowest_set_idx
   import onehot_enc_pkg::*;
#(
   parameter int N = 8,
   localparam int W = clog2(N)
) (
   input  logic [N-1:0] vec,
   output logic [W-1:0] idx,
   output logic         any,
   output logic         single
);

   always_comb begin
      idx = '0;
      for (int k = N - 1; k >= 0; k--) if (vec[k]) idx = W'(k);
   end

   assign any    = |vec;
   // Clearing the lowest set bit leaves zero only when exactly one bit was set.
   assign single = any && ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/onehot_encoder_stream.sv
// onehot_encoder_stream: captures a request vector and streams the index of each set bit, lowest first.
module onehot_encoder_stream
   import onehot_enc_pkg::*;
#(
   parameter int N      = 8,
   parameter bit STRICT = 1'b0,
   localparam int W     = clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_vec,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_idx,
   output logic         out_last,
   output logic         out_err,
   output logic         busy
);

   logic [1:0]   state_q, state_d;
   logic [N-1:0] pend_q, pend_d;
   logic [W-1:0] p_idx, v_idx;
   logic         p_any, p_single, v_any, v_single;
   logic         cap, emit, err, bad, unused;

   lowest_set_idx #(.N(N)) u_pend (.vec(pend_q), .idx(p_idx), .any(p_any), .single(p_single));
   lowest_set_idx #(.N(N)) u_in   (.vec(in_vec), .idx(v_idx), .any(v_any), .single(v_single));

   assign unused = ^{p_any, v_idx};

   assign emit = state_q == EMIT;
   assign err  = state_q == ERR;
   assign cap  = in_valid && in_ready;
   assign bad  = !v_any || (STRICT && !v_single);

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      if (state_q == IDLE && cap) begin
         state_d = bad ? ERR : EMIT;
         pend_d  = bad ? '0 : in_vec;
      end else if (emit && out_ready) begin
         pend_d  = pend_q & (pend_q - N'(1));
         state_d = p_single ? IDLE : EMIT;
      end else if ((err && out_ready) || state_q == 2'd3) begin
         pend_d  = '0;
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
      end
   end

   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = emit || err;
   assign out_idx   = emit ? p_idx : '0;
   assign out_last  = err || (emit && p_single);
   assign out_err   = err;
   assign busy      = state_q != IDLE;

endmodule

// File: doc/onehot_encoder_stream.md
Name: onehot_encoder_stream

Overview:
- Parametrised, clocked successor to the team's 8-to-3 one-hot encoder.
- Accepts an N-bit request vector over a valid/ready handshake and returns the binary index of each set bit, one per output beat, lowest bit first.
- In strict mode it checks that the vector is one-hot, returning a single index or an error beat.
- Sits between request-vector producers (arbiters, interrupt lines, keypads) and index-consuming logic, such as mux selects or display drivers.

Parameters:
- N, 8, input vector width; legal range 2..64.
- STRICT, 0; 0 = multi-hot mode, every set bit is emitted; 1 = one-hot mode, exactly one bit must be set.
- W, $clog2(N), localparam, output index width; 3 for the default N.

Ports:
- clk  in  1  system clock; all registers act on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_vec is presented.
- in_ready  out  1  block can capture a vector.
- in_vec  in  N  request vector; bit k set means index k.
- out_valid  out  1  output beat present.
- out_ready  in  1  consumer accepts the beat.
- out_idx  out  W  binary index of the current set bit.
- out_last  out  1  final beat for the captured vector.
- out_err  out  1  beat is an error beat; out_idx = 0 on error beats.
- busy  out  1  vector held, i.e. state != IDLE.

Behaviour:
- States: IDLE, EMIT, ERR. Registers: state, pend[N-1:0].
- Reset (async, rst=1):
  - state=IDLE, pend=0.
  - out_valid=0, out_idx=0, out_last=0, out_err=0, busy=0.
  - in_ready=0 while rst=1; in_ready=1 from the first edge after rst deasserts.
  - Reset mid-operation discards the held vector; no partial beat is completed.
- in_ready = (state==IDLE) & ~rst. Capture occurs on in_valid & in_ready.
- IDLE, on capture:
  - in_vec==0 -> ERR.
  - STRICT=1 and popcount(in_vec)!=1 -> ERR.
  - Otherwise pend<=in_vec, then EMIT.
- EMIT:
  - out_valid=1.
  - out_idx = index of the lowest set bit of pend.
  - out_last = 1 when exactly one bit of pend is set.
  - out_err = 0.
  - On out_ready: clear that bit in pend. If out_last, go to IDLE; otherwise stay in EMIT with the next bit.
- ERR:
  - out_valid=1, out_err=1, out_last=1, out_idx=0.
  - On out_ready: pend<=0, go to IDLE.
- Latency:
  - Capture at edge T gives out_valid=1 after edge T; the first beat is visible in cycle T+1.
  - A vector with K set bits takes K beats. Next capture is possible in the cycle after the last beat is accepted.
  - Peak throughput is one index per clock while out_ready=1.
- Backpressure: while out_valid=1 and out_ready=0, out_idx, out_last and out_err hold stable.
- No combinational path exists from in_* to out_*. All out_* are decoded from state and pend only.
- in_valid while busy is ignored because in_ready=0. The producer holds in_vec until capture.
- Bit N-1 set alone gives out_idx=N-1. No wrap-around beyond N-1 occurs.
- All-ones vector in multi-hot mode gives N beats, indices 0..N-1, with last on N-1.

Decomposition:
- Package onehot_enc_pkg holds:
  - the state encoding constants (IDLE=0, EMIT=1, ERR=2, 2-bit);
  - a clog2 constant function.
- Sub-module lowest_set_idx:
  - combinational, parameter N;
  - inputs: vec[N];
  - outputs: idx[W], any, single (exactly one bit set).
- The FSM instantiates lowest_set_idx once on pend. A second instance on in_vec supplies the strict-mode and zero checks at capture.

Test Plan:
- Reset during EMIT: N=8, STRICT=0, in_vec=8'b1010_0100 captured, assert rst after the first beat. -> All outputs 0 and busy=0 immediately. After release, in_ready=1 and no stale beats appear.
- Multi-hot with steady ready: N=8, STRICT=0, in_vec=8'b1010_0100, out_ready=1. -> Beats idx 2, 5, 7 on consecutive cycles. out_last only on 7, out_err=0. in_ready returns the next cycle.
- Backpressure hold: N=8, in_vec=8'b0001_1000, out_ready=0 for 3 cycles, then 1. -> idx=3 held stable for 4 cycles, then idx=4 with last=1.
- Strict-mode violation: STRICT=1, in_vec=8'b0100_0000 gives a single beat idx=6, last=1. Then in_vec=8'b0100_0001 gives a single beat out_err=1, idx=0, last=1.
- Zero vector and top bit: in_vec=0 (either mode) gives an error beat. N=16, in_vec=16'h8000 gives idx=15, last=1. N=16, in_vec=16'hFFFF gives 16 beats, idx 0..15.
- Busy rejection: in_valid held with a new vector while in EMIT. -> in_ready=0, new vector is not captured until the cycle after the final beat, then processed normally.
